// File: rtl/input_stream_pkg.sv
// Shared defaults, FSM state type and index-width helper for the input word streamer.
package input_stream_pkg;

    localparam int unsigned DEF_WORD_W    = 64;
    localparam int unsigned DEF_NUM_WORDS = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    function automatic int unsigned idx_width(input int unsigned num_words);
        return $clog2(num_words);
    endfunction

endpackage

// File: rtl/input_word_streamer_if.sv
// Load/stream handshake bundle for input_word_streamer.
// repeat_i exists only when INPUT_WORD_STREAMER_REPEAT_EN is defined.
interface input_word_streamer_if
    import input_stream_pkg::*;
#(
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned NUM_WORDS = DEF_NUM_WORDS
);
    localparam int unsigned IDX_W = idx_width(NUM_WORDS);

    logic                        load_valid_i;
    logic                        load_ready_o;
    logic [NUM_WORDS*WORD_W-1:0] block_i;
    logic [IDX_W-1:0]            start_word_i;
    logic                        flush_i;
    logic                        word_valid_o;
    logic                        word_ready_i;
    logic [WORD_W-1:0]           word_o;
    logic [IDX_W-1:0]            word_idx_o;
    logic                        last_o;
    logic                        busy_o;
`ifdef INPUT_WORD_STREAMER_REPEAT_EN
    logic                        repeat_i;
`endif

    // Streamer side
    modport slave (
        input  load_valid_i, block_i, start_word_i, flush_i, word_ready_i,
`ifdef INPUT_WORD_STREAMER_REPEAT_EN
        input  repeat_i,
`endif
        output load_ready_o, word_valid_o, word_o, word_idx_o, last_o, busy_o
    );

    // Producer/consumer side
    modport master (
        output load_valid_i, block_i, start_word_i, flush_i, word_ready_i,
`ifdef INPUT_WORD_STREAMER_REPEAT_EN
        output repeat_i,
`endif
        input  load_ready_o, word_valid_o, word_o, word_idx_o, last_o, busy_o
    );

endinterface

// File: rtl/input_word_mux.sv
// Combinational NUM_WORDS-to-1 selector of WORD_W-bit words out of a packed block.
module input_word_mux
    import input_stream_pkg::*;
#(
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic [NUM_WORDS*WORD_W-1:0]      block,
    input  logic [idx_width(NUM_WORDS)-1:0]  sel,
    output logic [WORD_W-1:0]                word_c
);
    localparam int unsigned IDX_W = idx_width(NUM_WORDS);

    always_comb begin
        word_c = '0;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (sel == IDX_W'(k)) word_c = block[k*WORD_W +: WORD_W];
        end
    end

endmodule

// File: rtl/input_word_streamer.sv
// Registers a block on load and streams its NUM_WORDS words from a start index, wrapping.
// Optional repeat feature: define INPUT_WORD_STREAMER_REPEAT_EN.
module input_word_streamer
    import input_stream_pkg::*;
#(
    parameter int unsigned WORD_W    = DEF_WORD_W,
    parameter int unsigned NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input_word_streamer_if.slave  bus
);
    localparam int unsigned IDX_W = idx_width(NUM_WORDS);
    localparam int unsigned BLK_W = NUM_WORDS * WORD_W;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic [BLK_W-1:0]   block_q;
    logic [WORD_W-1:0]  word_sel;
    logic               load_en;
    logic               last_c;
`ifdef INPUT_WORD_STREAMER_REPEAT_EN
    logic [IDX_W-1:0]   start_q;
`endif

    assign load_en = (state_q == IDLE) && bus.load_valid_i;
    assign last_c  = (count_q == IDX_W'(NUM_WORDS - 1));

    // State, position and block registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            count_q <= '0;
            block_q <= '0;
`ifdef INPUT_WORD_STREAMER_REPEAT_EN
            start_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            if (load_en) begin
                block_q <= bus.block_i;
`ifdef INPUT_WORD_STREAMER_REPEAT_EN
                start_q <= bus.start_word_i;
`endif
            end
        end
    end

    // Next state; flush outranks the word handshake
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (bus.load_valid_i) begin
                    state_d = STREAM;
                    idx_d   = bus.start_word_i;
                    count_d = '0;
                end
            end
            STREAM: begin
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else if (bus.word_ready_i) begin
                    if (last_c) begin
`ifdef INPUT_WORD_STREAMER_REPEAT_EN
                        if (bus.repeat_i) begin
                            idx_d   = start_q;
                            count_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        count_d = count_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    input_word_mux #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) u_mux (
        .block  (block_q),
        .sel    (idx_q),
        .word_c (word_sel)
    );

    // Outputs decoded from registered state only
    always_comb begin
        bus.load_ready_o = 1'b0;
        bus.word_valid_o = 1'b0;
        bus.busy_o       = 1'b0;
        bus.last_o       = 1'b0;
        bus.word_idx_o   = idx_q;
        bus.word_o       = word_sel;
        if (state_q == STREAM) begin
            bus.word_valid_o = 1'b1;
            bus.busy_o       = 1'b1;
            bus.last_o       = last_c;
        end else begin
            bus.load_ready_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_input_word_streamer.sv
// Self-checking bench for input_word_streamer: vector table, random streams vs. a
// queue-based word-order model, plus flush/reset/repeat sequences.
module tb_input_word_streamer;
    localparam int WW    = 64;
    localparam int NW    = 16;
    localparam int BLK_W = WW * NW;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    input_word_streamer_if #(.WORD_W(WW), .NUM_WORDS(NW)) bus ();

    input_word_streamer #(.WORD_W(WW), .NUM_WORDS(NW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] word;
        int            idx;
        logic          last;
    } exp_t;

    typedef struct {
        int start;
        bit ramp;
        int ready_pct;
        int flush_at;     // 1-based word number flushed with its handshake, 0 = none
        int exp_deliv;
        int exp_first;
        int exp_last;     // index seen with last_o, -1 = never
        int exp_cycles;   // -1 = not checked
    } vec_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic logic [WW-1:0] word_of(input logic [BLK_W-1:0] b, input int i);
        logic [BLK_W-1:0] t;
        t = b >> (i * WW);
        return t[WW-1:0];
    endfunction

    function automatic logic [BLK_W-1:0] ramp_block();
        logic [BLK_W-1:0] b;
        b = '0;
        for (int k = 0; k < NW; k++) b = b | ({{(BLK_W-WW){1'b0}}, 64'h1000 + 64'(k)} << (k * WW));
        return b;
    endfunction

    function automatic logic [BLK_W-1:0] rand_block();
        logic [BLK_W-1:0] b;
        for (int k = 0; k < BLK_W / 32; k++) b[k*32 +: 32] = $urandom;
        return b;
    endfunction

    // Expected order: NUM_WORDS words starting at start, index wrapping mod NUM_WORDS
    task automatic fill_model(input logic [BLK_W-1:0] b, input int start);
        exp_t e;
        for (int k = 0; k < NW; k++) begin
            e.idx  = (start + k) % NW;
            e.word = word_of(b, e.idx);
            e.last = (k == NW - 1);
            exp_q.push_back(e);
        end
    endtask

    // Called at #1 after a rising edge with the DUT idle
    task automatic run_stream(input int start, input logic [BLK_W-1:0] b, input int ready_pct,
                              input int flush_at, output int delivered, output int first_idx,
                              output int last_idx, output int cycles);
        logic [WW-1:0] pw;
        int            pidx;
        logic          plast;
        bit            pstall;
        bit            rdy;
        exp_t          h;
        exp_q.delete();
        fill_model(b, start);
        check("idle_load_ready", bus.load_ready_o, 1);
        bus.load_valid_i = 1'b1;
        bus.block_i      = b;
        bus.start_word_i = 4'(start);
        @(posedge clk); #1;
        bus.load_valid_i = 1'b0;
        bus.block_i      = ~b;
        bus.start_word_i = 4'($urandom);
        check("first_word_valid", bus.word_valid_o, 1);
        delivered = 0; last_idx = -1; cycles = 0; pstall = 0;
        first_idx = int'(bus.word_idx_o);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!bus.word_valid_o) break;
            cycles++;
            if (exp_q.size() == 0) begin
                check("extra_word", bus.word_valid_o, 0);
                break;
            end
            h = exp_q[0];
            check("word", bus.word_o, h.word);
            check("word_idx", 64'(bus.word_idx_o), 64'(h.idx));
            check("last", bus.last_o, h.last);
            check("stream_load_ready", bus.load_ready_o, 0);
            if (pstall) begin
                check("stall_word", bus.word_o, pw);
                check("stall_idx", 64'(bus.word_idx_o), 64'(pidx));
                check("stall_last", bus.last_o, plast);
            end
            rdy = ($urandom_range(0, 99) < ready_pct);
            if (flush_at > 0 && delivered == flush_at - 1) begin
                rdy = 1'b1;
                bus.flush_i = 1'b1;
            end
            bus.word_ready_i = rdy;
            if (rdy) begin
                delivered++;
                if (bus.last_o) last_idx = int'(bus.word_idx_o);
                void'(exp_q.pop_front());
            end
            pw = bus.word_o; pidx = int'(bus.word_idx_o); plast = bus.last_o; pstall = !rdy;
            @(posedge clk); #1;
            bus.flush_i = 1'b0;
        end
        bus.word_ready_i = 1'b0;
        check("stream_ended", bus.word_valid_o, 0);
        check("back_idle", bus.load_ready_o, 1);
        if (flush_at == 0) check("all_words_seen", 64'(exp_q.size()), 0);
    endtask

    vec_t tbl[6];
    int   dlv, fst, lst, cyc;
    int   st;
    logic [BLK_W-1:0] blk;

    initial begin
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0;
        bus.load_valid_i = 1'b0; bus.block_i = '0; bus.start_word_i = '0;
        bus.flush_i = 1'b0; bus.word_ready_i = 1'b0;
`ifdef INPUT_WORD_STREAMER_REPEAT_EN
        bus.repeat_i = 1'b0;
`endif
        #12;
        check("rst_valid", bus.word_valid_o, 0);
        check("rst_ready", bus.load_ready_o, 1);
        check("rst_busy", bus.busy_o, 0);
        check("rst_last", bus.last_o, 0);
        check("rst_word", bus.word_o, 0);
        check("rst_idx", 64'(bus.word_idx_o), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        tbl[0] = '{start: 0,  ramp: 1, ready_pct: 100, flush_at: 0, exp_deliv: 16, exp_first: 0,  exp_last: 15, exp_cycles: 16};
        tbl[1] = '{start: 14, ramp: 0, ready_pct: 100, flush_at: 0, exp_deliv: 16, exp_first: 14, exp_last: 13, exp_cycles: 16};
        tbl[2] = '{start: 5,  ramp: 0, ready_pct: 50,  flush_at: 0, exp_deliv: 16, exp_first: 5,  exp_last: 4,  exp_cycles: -1};
        tbl[3] = '{start: 0,  ramp: 1, ready_pct: 100, flush_at: 5, exp_deliv: 5,  exp_first: 0,  exp_last: -1, exp_cycles: 5};
        tbl[4] = '{start: 9,  ramp: 0, ready_pct: 50,  flush_at: 3, exp_deliv: 3,  exp_first: 9,  exp_last: -1, exp_cycles: -1};
        tbl[5] = '{start: 15, ramp: 0, ready_pct: 30,  flush_at: 0, exp_deliv: 16, exp_first: 15, exp_last: 14, exp_cycles: -1};

        for (int v = 0; v < 6; v++) begin
            blk = tbl[v].ramp ? ramp_block() : rand_block();
            run_stream(tbl[v].start, blk, tbl[v].ready_pct, tbl[v].flush_at, dlv, fst, lst, cyc);
            check($sformatf("v%0d_delivered", v), 64'(dlv), 64'(tbl[v].exp_deliv));
            check($sformatf("v%0d_first_idx", v), 64'(fst), 64'(tbl[v].exp_first));
            check($sformatf("v%0d_last_idx", v), 64'(lst), 64'(tbl[v].exp_last));
            if (tbl[v].exp_cycles >= 0)
                check($sformatf("v%0d_cycles", v), 64'(cyc), 64'(tbl[v].exp_cycles));
        end

        // Random streams against the order model
        for (int r = 0; r < 10; r++) begin
            st = int'($urandom_range(0, NW - 1));
            run_stream(st, rand_block(), int'($urandom_range(20, 90)), 0, dlv, fst, lst, cyc);
            check("rnd_delivered", 64'(dlv), 16);
            check("rnd_last_idx", 64'(lst), 64'((st + NW - 1) % NW));
        end

        // Flush while idle must not block a same-cycle load
        blk = rand_block();
        bus.load_valid_i = 1'b1; bus.flush_i = 1'b1; bus.block_i = blk; bus.start_word_i = 4'd7;
        @(posedge clk); #1;
        bus.load_valid_i = 1'b0; bus.flush_i = 1'b0;
        check("idle_flush_load", bus.word_valid_o, 1);
        check("idle_flush_word", bus.word_o, word_of(blk, 7));
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        check("flush_stall_idle", bus.word_valid_o, 0);

        // Reset pulsed at the 8th word
        bus.load_valid_i = 1'b1; bus.block_i = ramp_block(); bus.start_word_i = 4'd0;
        @(posedge clk); #1;
        bus.load_valid_i = 1'b0; bus.word_ready_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_word", bus.word_o, 64'h1007);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.word_valid_o, 0);
        check("mid_rst_ready", bus.load_ready_o, 1);
        check("mid_rst_word", bus.word_o, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("post_rst_no_word", bus.word_valid_o, 0);
        end
        bus.word_ready_i = 1'b0;

`ifdef INPUT_WORD_STREAMER_REPEAT_EN
        // Two back-to-back passes via repeat, no bubble
        begin
            int n;
            blk = rand_block();
            exp_q.delete();
            fill_model(blk, 3);
            fill_model(blk, 3);
            bus.load_valid_i = 1'b1; bus.block_i = blk; bus.start_word_i = 4'd3;
            @(posedge clk); #1;
            bus.load_valid_i = 1'b0; bus.word_ready_i = 1'b1;
            n = 0;
            for (int c = 0; c < 40; c++) begin
                if (!bus.word_valid_o) break;
                check("rep_word", bus.word_o, exp_q[0].word);
                void'(exp_q.pop_front());
                bus.repeat_i = (n < 16);
                n++;
                @(posedge clk); #1;
                if (exp_q.size() == 0) break;
            end
            bus.word_ready_i = 1'b0; bus.repeat_i = 1'b0;
            check("rep_count", 64'(n), 32);
            check("rep_end_idle", bus.word_valid_o, 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
